// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Instruction, data and memory bus signals of mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ready;

   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;

   logic        m_cs_n;
   logic        m_rd;
   logic        m_wr;
   logic [3:0]  m_be;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;

   // arbiter side
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
      output i_rdata, i_ready, d_rdata, d_ready,
      output m_cs_n, m_rd, m_wr, m_be, m_addr, m_wdata
   );

   // requesters and memory model side
   modport master (
      output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
      input  i_rdata, i_ready, d_rdata, d_ready,
      input  m_cs_n, m_rd, m_wr, m_be, m_addr, m_wdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one wait-stated memory between
//               instruction-fetch and data ports, one access in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);

   localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [3:0]  r_cnt;
   logic        r_last_grant;
   logic        r_sel;
   logic [31:0] r_addr;
   logic        r_we;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [31:0] r_i_rdata;
   logic [31:0] r_d_rdata;

   logic        w_grant;
   logic        w_grant_d;
   logic        w_access_done;

   // On conflict the port opposite the previous grant wins
   assign w_grant       = (r_state == ST_IDLE) && (bus.i_req || bus.d_req);
   assign w_grant_d     = bus.d_req && (!bus.i_req || !r_last_grant);
   assign w_access_done = (r_state == ST_ACCESS) && (r_cnt == 4'd0);

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      bus.m_cs_n   = 1'b1;
      bus.m_rd     = 1'b0;
      bus.m_wr     = 1'b0;
      bus.m_be     = 4'h0;
      bus.i_ready  = 1'b0;
      bus.d_ready  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant) begin
               w_state_next = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            bus.m_cs_n = 1'b0;
            bus.m_rd   = ~r_we;
            bus.m_wr   = r_we;
            bus.m_be   = r_be;
            if (w_access_done) begin
               w_state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            bus.i_ready  = ~r_sel;
            bus.d_ready  = r_sel;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_cnt        <= 4'd0;
         r_last_grant <= 1'b0;
         r_sel        <= 1'b0;
         r_addr       <= 32'h0;
         r_we         <= 1'b0;
         r_be         <= 4'h0;
         r_wdata      <= 32'h0;
         r_i_rdata    <= 32'h0;
         r_d_rdata    <= 32'h0;
      end else begin
         if (w_grant) begin
            r_sel        <= w_grant_d;
            r_last_grant <= w_grant_d;
            r_cnt        <= c_wait;
            r_wdata      <= bus.d_wdata;
            if (w_grant_d) begin
               r_addr <= bus.d_addr;
               r_we   <= bus.d_we;
               r_be   <= bus.d_be;
            end else begin
               r_addr <= bus.i_addr;
               r_we   <= 1'b0;
               r_be   <= 4'hF;
            end
         end else if (r_state == ST_ACCESS) begin
            if (r_cnt != 4'd0) begin
               r_cnt <= r_cnt - 4'd1;
            end else if (!r_sel) begin
               r_i_rdata <= bus.m_rdata;
            end else if (!r_we) begin
               // stores leave the data read register untouched
               r_d_rdata <= bus.m_rdata;
            end
         end
      end
   end

   assign bus.m_addr  = r_addr;
   assign bus.m_wdata = r_wdata;
   assign bus.i_rdata = r_i_rdata;
   assign bus.d_rdata = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter (WAIT 0/1/3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if bus ();
   mem_arbiter_if bus0 ();
   mem_arbiter_if bus3 ();

   mem_arbiter #(.WAIT_CYCLES(1)) u_dut    (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   mem_arbiter #(.WAIT_CYCLES(0)) u_dut_w0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   mem_arbiter #(.WAIT_CYCLES(3)) u_dut_w3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
   endtask

   // Waits for a ready pulse on the WAIT_CYCLES=1 instance, recording the
   // memory-side view of the access on the way.
   task automatic await_ready(input bit perturb, output int lat, output int cs_low,
                              output logic which_d, output logic both,
                              output logic [5:0] ctl, output logic [31:0] first_addr,
                              output logic [31:0] first_wdata, output logic [31:0] last_addr);
      lat = 99; cs_low = 0; which_d = 1'b0; both = 1'b0;
      ctl = 6'h0; first_addr = 32'h0; first_wdata = 32'h0; last_addr = 32'h0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (!bus.m_cs_n) begin
            cs_low++;
            if (cs_low == 1) begin
               ctl         = {bus.m_rd, bus.m_wr, bus.m_be};
               first_addr  = bus.m_addr;
               first_wdata = bus.m_wdata;
               if (perturb) begin
                  bus.i_addr = 32'hFFFF_0000;
                  bus.d_addr = 32'hFFFF_0004;
               end
            end
            last_addr = bus.m_addr;
         end
         if (bus.i_ready || bus.d_ready) begin
            lat     = k;
            which_d = bus.d_ready;
            both    = bus.i_ready & bus.d_ready;
            break;
         end
      end
   endtask

   int          lat, cs_low, nrdy;
   logic        wd, both;
   logic [5:0]  ctl;
   logic [31:0] fa, fw, la;
   logic [3:0]  seq;
   logic [3:0]  lats_ok;

   initial begin
      bus.i_req  = 0; bus.i_addr  = 0; bus.d_req  = 0; bus.d_we  = 0;
      bus.d_be   = 0; bus.d_addr  = 0; bus.d_wdata = 0; bus.m_rdata = 0;
      bus0.i_req = 0; bus0.i_addr = 0; bus0.d_req = 0; bus0.d_we = 0;
      bus0.d_be  = 0; bus0.d_addr = 0; bus0.d_wdata = 0; bus0.m_rdata = 0;
      bus3.i_req = 0; bus3.i_addr = 0; bus3.d_req = 0; bus3.d_we = 0;
      bus3.d_be  = 0; bus3.d_addr = 0; bus3.d_wdata = 0; bus3.m_rdata = 0;

      repeat (2) @(negedge clk);
      check("rst_cs_n", 32'(bus.m_cs_n), 32'd1);
      check("rst_ctl", 32'({bus.i_ready, bus.d_ready, bus.m_rd, bus.m_wr, bus.m_be}), 32'd0);
      check("rst_m_addr", bus.m_addr, 32'h0);
      check("rst_m_wdata", bus.m_wdata, 32'h0);
      check("rst_rdata", bus.i_rdata | bus.d_rdata, 32'h0);
      rst_n = 1'b0;
      @(negedge clk);

      // instruction fetch, address disturbed mid-access
      bus.i_req = 1; bus.i_addr = 32'h100; bus.m_rdata = 32'h0050_0093;
      await_ready(1'b1, lat, cs_low, wd, both, ctl, fa, fw, la);
      bus.i_req = 0;
      check("fetch_lat", lat, 3);
      check("fetch_cs_low", cs_low, 2);
      check("fetch_port", 32'(wd), 32'd0);
      check("fetch_ctl", 32'(ctl), 32'(6'b10_1111));
      check("fetch_addr", fa, 32'h100);
      check("fetch_addr_hold", la, 32'h100);
      check("fetch_rdata", bus.i_rdata, 32'h0050_0093);
      @(negedge clk);

      // data load
      bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h3000;
      bus.m_rdata = 32'hCAFE_F00D;
      await_ready(1'b0, lat, cs_low, wd, both, ctl, fa, fw, la);
      bus.d_req = 0;
      check("load_port", 32'(wd), 32'd1);
      check("load_addr", fa, 32'h3000);
      check("load_ctl", 32'(ctl), 32'(6'b10_1111));
      check("load_rdata", bus.d_rdata, 32'hCAFE_F00D);
      check("load_i_rdata_hold", bus.i_rdata, 32'h0050_0093);
      @(negedge clk);

      // data store
      bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011; bus.d_addr = 32'h2000;
      bus.d_wdata = 32'hDEAD_BEEF; bus.m_rdata = 32'h1234_5678;
      await_ready(1'b0, lat, cs_low, wd, both, ctl, fa, fw, la);
      bus.d_req = 0; bus.d_we = 0;
      check("store_lat", lat, 3);
      check("store_port", 32'(wd), 32'd1);
      check("store_ctl", 32'(ctl), 32'(6'b01_0011));
      check("store_addr", fa, 32'h2000);
      check("store_wdata", fw, 32'hDEAD_BEEF);
      check("store_d_rdata_hold", bus.d_rdata, 32'hCAFE_F00D);
      @(negedge clk);

      // reset asserted in the middle of a data access
      bus.d_req = 1; bus.d_addr = 32'h4000; bus.m_rdata = 32'h5555_AAAA;
      @(negedge clk);
      check("abort_in_access", 32'(bus.m_cs_n), 32'd0);
      #2 rst_n = 1'b1;
      #1;
      check("abort_cs_n", 32'(bus.m_cs_n), 32'd1);
      check("abort_ctl", 32'({bus.i_ready, bus.d_ready, bus.m_rd, bus.m_wr, bus.m_be}), 32'd0);
      check("abort_m_addr", bus.m_addr, 32'h0);
      check("abort_rdata", bus.d_rdata | bus.i_rdata, 32'h0);
      bus.d_req = 0;
      @(negedge clk);
      rst_n = 1'b0;
      nrdy = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.i_ready || bus.d_ready) nrdy++;
      end
      check("abort_no_ready", nrdy, 0);

      // simultaneous requests after reset: D, I, D, I
      bus.i_req = 1; bus.i_addr = 32'h500; bus.d_req = 1; bus.d_addr = 32'h600;
      bus.d_we = 0; bus.m_rdata = 32'h1111_0000;
      seq = 4'h0; lats_ok = 4'h0;
      for (int g = 0; g < 4; g++) begin
         await_ready(1'b0, lat, cs_low, wd, both, ctl, fa, fw, la);
         seq[3-g]     = wd;
         lats_ok[3-g] = (lat == ((g == 0) ? 3 : 4)) && !both;
         if (g == 0) check("rr_first_addr", fa, 32'h600);
         if (g == 1) check("rr_second_addr", fa, 32'h500);
      end
      bus.i_req = 0; bus.d_req = 0;
      check("rr_sequence", 32'(seq), 32'(4'b1010));
      check("rr_latency", 32'(lats_ok), 32'(4'b1111));
      check("rr_rdata", bus.i_rdata ^ bus.d_rdata, 32'h0);
      @(negedge clk);

      // zero wait states
      bus0.d_req = 1; bus0.d_addr = 32'h10; bus0.m_rdata = 32'hA0A0_A0A0;
      lat = 99;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus0.d_ready) begin lat = k; break; end
      end
      bus0.d_req = 0;
      check("w0_lat", lat, 2);
      check("w0_rdata", bus0.d_rdata, 32'hA0A0_A0A0);

      // three wait states
      bus3.d_req = 1; bus3.d_addr = 32'h20; bus3.m_rdata = 32'h0B0B_0B0B;
      lat = 99;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (bus3.d_ready) begin lat = k; break; end
      end
      bus3.d_req = 0;
      check("w3_lat", lat, 5);
      check("w3_rdata", bus3.d_rdata, 32'h0B0B_0B0B);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, memory wait states per access (legal 0..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous reset, active-high (1 = reset asserted).
REQ-004 i_req  input  1  instruction-fetch request; held until i_ready.
REQ-005 i_addr  input  32  instruction fetch address.
REQ-006 i_rdata  output  32  fetched instruction word; valid while i_ready=1.
REQ-007 i_ready  output  1  one-cycle completion pulse for fetch.
REQ-008 d_req  input  1  data request; held until d_ready.
REQ-009 d_we  input  1  1 = store, 0 = load.
REQ-010 d_be  input  4  store byte enables.
REQ-011 d_addr  input  32  data address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_rdata  output  32  load data; valid while d_ready=1.
REQ-014 d_ready  output  1  one-cycle completion pulse for data access.
REQ-015 m_cs_n  output  1  memory chip select, active-low.
REQ-016 m_rd  output  1  memory read strobe.
REQ-017 m_wr  output  1  memory write strobe.
REQ-018 m_be  output  4  memory byte enables.
REQ-019 m_addr  output  32  memory address.
REQ-020 m_wdata  output  32  memory write data.
REQ-021 m_rdata  input  32  memory read data; sampled on last access cycle.

Function
REQ-022 FSM states IDLE, ACCESS, RESP; register last_grant (0 = instruction, 1 = data).
REQ-023 IDLE: no request -> stay; one request -> grant it; both -> grant port opposite last_grant.
REQ-024 On grant: latch port select, address, d_we, d_be, d_wdata; load wait counter = WAIT_CYCLES; update last_grant; go ACCESS.
REQ-025 Instruction grants always read (m_rd=1, m_wr=0, m_be=4'hF).
REQ-026 ACCESS: m_cs_n=0, m_addr/m_wdata/m_be from latches, m_rd=~we, m_wr=we; counter>0 -> decrement; counter==0 -> capture m_rdata into read register, go RESP.
REQ-027 ACCESS lasts exactly WAIT_CYCLES+1 cycles; latched values stable throughout, independent of requester inputs.
REQ-028 RESP: granted port's ready=1 for exactly one cycle, rdata = captured word; m_cs_n=1, m_rd=m_wr=0; go IDLE unconditionally.
REQ-029 Latency: request seen in IDLE cycle c -> ready in cycle c+WAIT_CYCLES+2; max throughput one access per WAIT_CYCLES+3 cycles.
REQ-030 Outside ACCESS: m_cs_n=1, m_rd=0, m_wr=0, m_be=0.
REQ-031 i_rdata/d_rdata hold last captured value for their port; stores leave d_rdata unchanged.
REQ-032 Ungranted request remains pending with no side effect; requests dropped before grant are ignored.
REQ-033 Request arriving in ACCESS or RESP is not evaluated until next IDLE cycle.
REQ-034 Never both i_ready and d_ready high; never more than one access in flight.

Reset
REQ-035 rst_n=1 immediately (asynchronously) forces IDLE, counter=0, last_grant=0, i_ready=d_ready=0, m_cs_n=1, m_rd=m_wr=0, m_be=0, m_addr=m_wdata=0, i_rdata=d_rdata=0.
REQ-036 Reset during ACCESS aborts the access with no ready pulse; first post-reset conflict grants data.

Verification
REQ-037 WAIT_CYCLES=1, i_req only, i_addr=0x100, m_rdata=0x00500093 -> m_cs_n low 2 cycles, i_ready in cycle c+3, i_rdata=0x00500093.
REQ-038 d_req, d_we=1, d_be=4'b0011, d_addr=0x2000, d_wdata=0xDEADBEEF -> m_wr=1, m_rd=0, m_be=0011 during ACCESS, d_ready pulse, d_rdata unchanged.
REQ-039 After reset, i_req and d_req same cycle -> data served first, then instruction; grants alternate D,I,D,I while both held.
REQ-040 WAIT_CYCLES=0 and 3, single loads -> ready at c+2 and c+5 respectively.
REQ-041 rst_n pulsed mid-ACCESS -> all outputs at reset values same cycle, no ready pulse, fresh request completes normally.
REQ-042 i_addr changed during ACCESS -> m_addr stays at latched value until RESP.
